alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Three-state (IDLE / EXEC / DONE) sequencer in front of an external
//   combinational ALU. It latches one instruction, presents the operands from
//   a 4 x 8-bit register file for one cycle, writes the ALU result back into
//   R[rd], updates the status flags and pulses done.
//
//   Instruction word: [15:13] op, [12:11] rd, [10:9] rs, [8] use_imm, [7:0] imm
//   Ops 000-101 write back; ops 110/111 write nothing and keep the flags.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr_valid, instr          instruction handshake (accepted in IDLE only)
//   instr_ready                 high in IDLE while out of reset
//   alu_a, alu_b, alu_op        ALU operands/opcode, non-zero only in EXEC
//   alu_result, alu_zero,
//   alu_overflow, alu_carry     combinational ALU result and flags
//   zf, cf, vf                  registered status flags
//   done                        one-cycle completion pulse (DONE state)
//   dbg_addr, dbg_data          combinational register-file read port
//
// Build option
//   STICKY_OVF_EN  when defined, vf accumulates overflow of add/sub and is
//                  cleared only by reset.
// ---------------------------------------------------------------------------
module alu_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   input  logic [7:0]  alu_result,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   input  logic        alu_carry,
   output logic        zf,
   output logic        cf,
   output logic        vf,
   output logic        done,
   input  logic [1:0]  dbg_addr,
   output logic [7:0]  dbg_data
);

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t            state_r;
   state_t            state_nxt;
   logic [15:0]       instr_p1;
   logic [DATA_W-1:0] rf [4];

   logic [2:0] op_p1;
   logic [1:0] rd_p1;
   logic [1:0] rs_p1;
   logic       use_imm_p1;
   logic [7:0] imm_p1;
   logic       vld_p1;
   logic       wr_en;
   logic       arith;

   assign op_p1      = instr_p1[15:13];
   assign rd_p1      = instr_p1[12:11];
   assign rs_p1      = instr_p1[10:9];
   assign use_imm_p1 = instr_p1[8];
   assign imm_p1     = instr_p1[7:0];

   assign vld_p1 = (state_r == S_EXEC);
   assign wr_en  = vld_p1 && (op_p1 < 3'b110);
   assign arith  = (op_p1 == 3'b000) || (op_p1 == 3'b001);

   assign dbg_data = rf[dbg_addr];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= S_IDLE;
      else        state_r <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         S_IDLE:  if (instr_valid) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs; instr_ready is gated by rst_n so it stays low while in reset
   always_comb begin
      instr_ready = rst_n && (state_r == S_IDLE);
      done        = (state_r == S_DONE);
      alu_a       = '0;
      alu_b       = '0;
      alu_op      = '0;
      if (vld_p1) begin
         alu_a  = rf[rd_p1];
         alu_b  = use_imm_p1 ? imm_p1 : rf[rs_p1];
         alu_op = op_p1;
      end
   end

   // Stage p0 -> p1: instruction capture (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (state_r == S_IDLE && instr_valid) instr_p1 <= instr;
   end

   // Stage p1 -> writeback: register file and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) rf[i] <= '0;
         zf <= 1'b0;
         cf <= 1'b0;
         vf <= 1'b0;
      end else if (wr_en) begin
         rf[rd_p1] <= alu_result;
         zf        <= alu_zero;
         cf        <= arith ? alu_carry : 1'b0;
`ifdef STICKY_OVF_EN
         if (arith) vf <= vf | alu_overflow;
`else
         vf        <= arith ? alu_overflow : 1'b0;
`endif
      end
   end

endmodule
